// File: rtl/multi_issue_inst_queue_pkg.sv
// Shared constants and helpers for the multi-issue instruction queue.
// Package: inst_queue_pkg
//   - default lane counts, payload width and depth
//   - lane_bus_w(): width of a flattened multi-lane bus
//   - lane_lsb():   LSB of lane k in a bus where lane 0 is the most-significant slice
package inst_queue_pkg;

  localparam int unsigned IIQ_ENQ_LANES_DEF  = 4;
  localparam int unsigned IIQ_DEQ_LANES_DEF  = 4;
  localparam int unsigned IIQ_ENTRY_W_DEF    = 256;
  localparam int unsigned IIQ_DEPTH_LOG2_DEF = 4;
  localparam int unsigned IIQ_STAT_W         = 32;

  // Total width of a flattened bus of 'lanes' slices of 'w' bits.
  function automatic int unsigned lane_bus_w(input int unsigned lanes, input int unsigned w);
    return lanes * w;
  endfunction

  // Lane 0 sits in the top slice, so lane k starts (lanes-1-k) slices up.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lanes,
                                           input int unsigned w);
    return (lanes - 1 - lane) * w;
  endfunction

endpackage

// File: rtl/multi_issue_inst_queue_if.sv
// Enqueue/dequeue/status bundle of the multi-issue instruction queue.
// slave  : the queue (takes enqValid_i/enqData_i/deqPop_i, drives the rest)
// master : decoder + backend side (drives enqValid_i/enqData_i/deqPop_i)
interface multi_issue_inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int unsigned ENQ_LANES  = IIQ_ENQ_LANES_DEF,
  parameter int unsigned DEQ_LANES  = IIQ_DEQ_LANES_DEF,
  parameter int unsigned ENTRY_W    = IIQ_ENTRY_W_DEF,
  parameter int unsigned DEPTH_LOG2 = IIQ_DEPTH_LOG2_DEF
) ();

  localparam int unsigned ENQ_BUS_W = lane_bus_w(ENQ_LANES, ENTRY_W);
  localparam int unsigned DEQ_BUS_W = lane_bus_w(DEQ_LANES, ENTRY_W);
  localparam int unsigned POP_W     = $clog2(DEQ_LANES + 1);

  logic [ENQ_LANES-1:0]  enqValid_i;
  logic [ENQ_BUS_W-1:0]  enqData_i;
  logic                  enqReady_o;
  logic [DEQ_LANES-1:0]  deqValid_o;
  logic [DEQ_BUS_W-1:0]  deqData_o;
  logic [POP_W-1:0]      deqPop_i;
  logic [DEPTH_LOG2:0]   count_o;
  logic [DEPTH_LOG2-1:0] head_o;
  logic [DEPTH_LOG2-1:0] tail_o;
  logic                  empty_o;
  logic                  full_o;

  modport slave (
    input  enqValid_i, enqData_i, deqPop_i,
    output enqReady_o, deqValid_o, deqData_o, count_o, head_o, tail_o, empty_o, full_o
  );

  modport master (
    output enqValid_i, enqData_i, deqPop_i,
    input  enqReady_o, deqValid_o, deqData_o, count_o, head_o, tail_o, empty_o, full_o
  );

endinterface

// File: rtl/multi_issue_inst_queue_iiq_ram.sv
// Payload storage: ENQ_LANES write ports, DEQ_LANES asynchronous read ports.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i per write lane;
//        rd_addr_i/rd_data_o per read lane. Contents are never reset.
module iiq_ram
  import inst_queue_pkg::*;
#(
  parameter int unsigned ENQ_LANES  = IIQ_ENQ_LANES_DEF,
  parameter int unsigned DEQ_LANES  = IIQ_DEQ_LANES_DEF,
  parameter int unsigned ENTRY_W    = IIQ_ENTRY_W_DEF,
  parameter int unsigned DEPTH_LOG2 = IIQ_DEPTH_LOG2_DEF
) (
  input  logic                                  clk_i,
  input  logic [ENQ_LANES-1:0]                  wr_en_i,
  input  logic [ENQ_LANES-1:0][DEPTH_LOG2-1:0]  wr_addr_i,
  input  logic [ENQ_LANES-1:0][ENTRY_W-1:0]     wr_data_i,
  input  logic [DEQ_LANES-1:0][DEPTH_LOG2-1:0]  rd_addr_i,
  output logic [DEQ_LANES-1:0][ENTRY_W-1:0]     rd_data_o
);

  localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;

  logic [ENTRY_W-1:0] mem_q [ENTRIES];
  logic [ENTRY_W-1:0] mem_d [ENTRIES];

  // Write lanes target distinct slots whenever they are enabled together.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < int'(ENQ_LANES); k++) begin
      if (wr_en_i[k]) mem_d[wr_addr_i[k]] = wr_data_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Asynchronous read window.
  always_comb begin
    for (int i = 0; i < int'(DEQ_LANES); i++) begin
      rd_data_o[i] = mem_q[rd_addr_i[i]];
    end
  end

endmodule

// File: rtl/multi_issue_inst_queue.sv
// Multi-issue circular instruction queue with first-word-fall-through dequeue.
// Ports: clock_i, reset_i (sync, active-low), flush_i, q_if (slave modport:
//   enqValid_i/enqData_i/enqReady_o, deqValid_o/deqData_o/deqPop_i,
//   count_o, head_o, tail_o, empty_o, full_o).
// Optional macro IIQ_STATS_EN adds highWater_o and stallCycles_o.
module multi_issue_inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned ENQ_LANES  = IIQ_ENQ_LANES_DEF,
  parameter int unsigned DEQ_LANES  = IIQ_DEQ_LANES_DEF,
  parameter int unsigned ENTRY_W    = IIQ_ENTRY_W_DEF,
  parameter int unsigned DEPTH_LOG2 = IIQ_DEPTH_LOG2_DEF
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  multi_issue_inst_queue_if.slave  q_if
`ifdef IIQ_STATS_EN
  ,
  output logic [DEPTH_LOG2:0]      highWater_o,
  output logic [IIQ_STAT_W-1:0]    stallCycles_o
`endif
);

  localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned ECNT_W  = $clog2(ENQ_LANES + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ECNT_W-1:0] enq_cnt;
  logic              lead_run;
  logic              enq_ok;
  logic [CNT_W-1:0]  enq_acc;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  pop_req;
  logic [CNT_W-1:0]  pop_eff;

  logic [ENQ_LANES-1:0]             wr_en;
  logic [ENQ_LANES-1:0][PTR_W-1:0]  wr_addr;
  logic [ENQ_LANES-1:0][ENTRY_W-1:0] wr_data;
  logic [DEQ_LANES-1:0][PTR_W-1:0]  rd_addr;
  logic [DEQ_LANES-1:0][ENTRY_W-1:0] rd_data;

  // Length of the leading run of valid lanes; anything after a gap is ignored.
  always_comb begin
    enq_cnt  = '0;
    lead_run = 1'b1;
    for (int k = 0; k < int'(ENQ_LANES); k++) begin
      if (lead_run && q_if.enqValid_i[k]) enq_cnt = enq_cnt + ECNT_W'(1);
      else                                lead_run = 1'b0;
    end
  end

  // All-or-none acceptance against the pre-cycle occupancy.
  assign enq_ok = (CNT_W'(ENTRIES) - count_q) >= CNT_W'(enq_cnt);
  assign q_if.enqReady_o = enq_ok;

  // Next pointers/occupancy; flush wins over enqueue and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    avail   = (count_q > CNT_W'(DEQ_LANES)) ? CNT_W'(DEQ_LANES) : count_q;
    pop_req = CNT_W'(q_if.deqPop_i);
    pop_eff = (pop_req > avail) ? avail : pop_req;
    enq_acc = enq_ok ? CNT_W'(enq_cnt) : '0;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_eff);
      tail_d  = tail_q + PTR_W'(enq_acc);
      count_d = count_q + enq_acc - pop_eff;
    end
  end

  // Write lanes k < enq_cnt land at tail+k; nothing is written under reset or flush.
  always_comb begin
    for (int k = 0; k < int'(ENQ_LANES); k++) begin
      wr_en[k]   = reset_i && !flush_i && enq_ok && (ECNT_W'(k) < enq_cnt);
      wr_addr[k] = tail_q + PTR_W'(k);
      wr_data[k] = q_if.enqData_i[lane_lsb(k, ENQ_LANES, ENTRY_W) +: ENTRY_W];
    end
  end

  // Head window read straight from registered pointers.
  always_comb begin
    q_if.deqData_o = '0;
    for (int i = 0; i < int'(DEQ_LANES); i++) begin
      rd_addr[i]         = head_q + PTR_W'(i);
      q_if.deqValid_o[i] = count_q > CNT_W'(i);
      q_if.deqData_o[lane_lsb(i, DEQ_LANES, ENTRY_W) +: ENTRY_W] = rd_data[i];
    end
  end

  iiq_ram #(
    .ENQ_LANES  (ENQ_LANES),
    .DEQ_LANES  (DEQ_LANES),
    .ENTRY_W    (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i     (clock_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign q_if.count_o = count_q;
  assign q_if.head_o  = head_q;
  assign q_if.tail_o  = tail_q;
  assign q_if.empty_o = (count_q == '0);
  assign q_if.full_o  = (count_q == CNT_W'(ENTRIES));

`ifdef IIQ_STATS_EN
  logic [CNT_W-1:0]      hw_q, hw_d;
  logic [IIQ_STAT_W-1:0] stall_q, stall_d;

  // High-water tracks next occupancy so it agrees with count_o; flush leaves both alone.
  always_comb begin
    hw_d    = (count_d > hw_q) ? count_d : hw_q;
    stall_d = stall_q;
    if ((|q_if.enqValid_i) && !enq_ok && (stall_q != '1)) stall_d = stall_q + IIQ_STAT_W'(1);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      hw_q    <= '0;
      stall_q <= '0;
    end else begin
      hw_q    <= hw_d;
      stall_q <= stall_d;
    end
  end

  assign highWater_o   = hw_q;
  assign stallCycles_o = stall_q;
`endif

endmodule

// File: tb/tb_multi_issue_inst_queue.sv
// Directed bench for multi_issue_inst_queue (4 lanes, 16 entries, 32-bit payload).
// Build with IIQ_STATS_EN defined to also exercise the statistics outputs.
module tb_multi_issue_inst_queue;

  localparam int unsigned EL = 4;
  localparam int unsigned DL = 4;
  localparam int unsigned EW = 32;
  localparam int unsigned DG = 4;

  logic clk;
  logic rst_n;
  logic flush;
  int   vec_cnt;
  int   miss_cnt;

`ifdef IIQ_STATS_EN
  logic [DG:0]   high_water;
  logic [31:0]   stall_cycles;
`endif

  multi_issue_inst_queue_if #(
    .ENQ_LANES(EL), .DEQ_LANES(DL), .ENTRY_W(EW), .DEPTH_LOG2(DG)
  ) q_if ();

  multi_issue_inst_queue #(
    .ENQ_LANES(EL), .DEQ_LANES(DL), .ENTRY_W(EW), .DEPTH_LOG2(DG)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .flush_i       (flush),
    .q_if          (q_if)
`ifdef IIQ_STATS_EN
    ,
    .highWater_o   (high_water),
    .stallCycles_o (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input int n, input logic [31:0] base);
    q_if.enqValid_i = '0;
    q_if.enqData_i  = '0;
    for (int k = 0; k < n; k++) begin
      q_if.enqValid_i[k] = 1'b1;
      q_if.enqData_i[(EL-1-k)*EW +: EW] = base + 32'(k);
    end
  endtask

  function automatic logic [31:0] lane(input int i);
    return q_if.deqData_o[(DL-1-i)*EW +: EW];
  endfunction

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    q_if.deqPop_i = '0;
    set_enq(0, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(q_if.count_o), 64'd0);
    chk("rst_deqvalid", 64'(q_if.deqValid_o), 64'd0);
    chk("rst_empty", 64'(q_if.empty_o), 64'd1);
    chk("rst_full", 64'(q_if.full_o), 64'd0);
    chk("rst_ready", 64'(q_if.enqReady_o), 64'd1);
    chk("rst_head", 64'(q_if.head_o), 64'd0);
    chk("rst_tail", 64'(q_if.tail_o), 64'd0);

    // First group of four.
    set_enq(4, 32'h0);
    step();
    set_enq(0, 0);
    #1;
    chk("enq4_count", 64'(q_if.count_o), 64'd4);
    chk("enq4_valid", 64'(q_if.deqValid_o), 64'hF);
    chk("enq4_lane0", 64'(lane(0)), 64'h0);
    chk("enq4_lane3", 64'(lane(3)), 64'h3);
    chk("enq4_tail", 64'(q_if.tail_o), 64'd4);

    // Fill to 12, then the last four fit exactly.
    set_enq(4, 32'h4);
    step();
    set_enq(4, 32'h8);
    step();
    set_enq(4, 32'hC);
    #1;
    chk("c12_count", 64'(q_if.count_o), 64'd12);
    chk("c12_ready", 64'(q_if.enqReady_o), 64'd1);
    step();
    set_enq(4, 32'h10);
    #1;
    chk("full_flag", 64'(q_if.full_o), 64'd1);
    chk("full_count", 64'(q_if.count_o), 64'd16);
    // Five blocked cycles with a full queue.
    for (int i = 0; i < 5; i++) begin
      chk("blk_ready", 64'(q_if.enqReady_o), 64'd0);
      step();
      chk("blk_count", 64'(q_if.count_o), 64'd16);
    end
    set_enq(0, 0);
    #1;
    chk("full_idle_ready", 64'(q_if.enqReady_o), 64'd1);
    chk("full_head", 64'(q_if.head_o), 64'd0);
    chk("full_tail", 64'(q_if.tail_o), 64'd0);
    chk("win_l0", 64'(lane(0)), 64'h0);
    chk("win_l2", 64'(lane(2)), 64'h2);
`ifdef IIQ_STATS_EN
    chk("stat_stall5", 64'(stall_cycles), 64'd5);
    chk("stat_hw16", 64'(high_water), 64'd16);
`endif

    // Pops, including an over-large pop that must clamp.
    q_if.deqPop_i = 3'd4;
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("pop4_count", 64'(q_if.count_o), 64'd12);
    chk("pop4_head", 64'(q_if.head_o), 64'd4);
    chk("pop4_lane0", 64'(lane(0)), 64'h4);
    q_if.deqPop_i = 3'd7;
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("pop7_count", 64'(q_if.count_o), 64'd8);
    chk("pop7_head", 64'(q_if.head_o), 64'd8);
    chk("pop7_lane3", 64'(lane(3)), 64'hB);
    q_if.deqPop_i = 3'd4;
    step();
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("drain_count", 64'(q_if.count_o), 64'd0);
    chk("drain_empty", 64'(q_if.empty_o), 64'd1);
    chk("drain_head", 64'(q_if.head_o), 64'd0);
    q_if.deqPop_i = 3'd3;
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("pop_empty_head", 64'(q_if.head_o), 64'd0);
    chk("pop_empty_count", 64'(q_if.count_o), 64'd0);

    // Bring tail to 14, then enqueue across the wrap.
    set_enq(4, 32'h10);
    step();
    set_enq(4, 32'h14);
    step();
    set_enq(4, 32'h18);
    step();
    set_enq(2, 32'h1C);
    step();
    set_enq(0, 0);
    #1;
    chk("t14_tail", 64'(q_if.tail_o), 64'd14);
    chk("t14_count", 64'(q_if.count_o), 64'd14);
    q_if.deqPop_i = 3'd4;
    step();
    q_if.deqPop_i = 3'd0;
    set_enq(4, 32'hA0);
    #1;
    chk("wrap_ready", 64'(q_if.enqReady_o), 64'd1);
    step();
    set_enq(0, 0);
    #1;
    chk("wrap_tail", 64'(q_if.tail_o), 64'd2);
    chk("wrap_count", 64'(q_if.count_o), 64'd14);
    chk("wrap_head", 64'(q_if.head_o), 64'd4);
    q_if.deqPop_i = 3'd4;
    step();
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("h12_lane0", 64'(lane(0)), 64'h1C);
    chk("h12_lane1", 64'(lane(1)), 64'h1D);
    chk("h12_lane2", 64'(lane(2)), 64'hA0);
    chk("h12_lane3", 64'(lane(3)), 64'hA1);
    q_if.deqPop_i = 3'd2;
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("h14_head", 64'(q_if.head_o), 64'd14);
    chk("h14_lane0", 64'(lane(0)), 64'hA0);
    chk("h14_lane1", 64'(lane(1)), 64'hA1);
    chk("h14_lane2", 64'(lane(2)), 64'hA2);
    chk("h14_lane3", 64'(lane(3)), 64'hA3);

    // Count 3, then enqueue 2 with pop 3 in one cycle.
    q_if.deqPop_i = 3'd1;
    step();
    q_if.deqPop_i = 3'd0;
    #1;
    chk("c3_count", 64'(q_if.count_o), 64'd3);
    chk("c3_valid", 64'(q_if.deqValid_o), 64'h7);
    set_enq(2, 32'hB0);
    q_if.deqPop_i = 3'd3;
    #1;
    chk("simul_ready", 64'(q_if.enqReady_o), 64'd1);
    step();
    set_enq(0, 0);
    q_if.deqPop_i = 3'd0;
    #1;
    chk("simul_count", 64'(q_if.count_o), 64'd2);
    chk("simul_head", 64'(q_if.head_o), 64'd2);
    chk("simul_tail", 64'(q_if.tail_o), 64'd4);
    chk("simul_valid", 64'(q_if.deqValid_o), 64'h3);
    chk("simul_lane0", 64'(lane(0)), 64'hB0);
    chk("simul_lane1", 64'(lane(1)), 64'hB1);

    // Flush together with a full enqueue group.
    set_enq(4, 32'hC0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_enq(0, 0);
    #1;
    chk("flush_count", 64'(q_if.count_o), 64'd0);
    chk("flush_empty", 64'(q_if.empty_o), 64'd1);
    chk("flush_valid", 64'(q_if.deqValid_o), 64'd0);
    chk("flush_head", 64'(q_if.head_o), 64'd0);
    chk("flush_tail", 64'(q_if.tail_o), 64'd0);
`ifdef IIQ_STATS_EN
    chk("flush_hw", 64'(high_water), 64'd16);
    chk("flush_stall", 64'(stall_cycles), 64'd5);
`endif
    set_enq(1, 32'hD0);
    step();
    set_enq(0, 0);
    #1;
    chk("post_flush_count", 64'(q_if.count_o), 64'd1);
    chk("post_flush_lane0", 64'(lane(0)), 64'hD0);

    // Non-contiguous valid: only lanes 0 and 1 count.
    set_enq(4, 32'hE0);
    q_if.enqValid_i = 4'b1011;
    step();
    set_enq(0, 0);
    #1;
    chk("nc_count", 64'(q_if.count_o), 64'd3);
    chk("nc_tail", 64'(q_if.tail_o), 64'd3);
    chk("nc_lane1", 64'(lane(1)), 64'hE0);
    chk("nc_lane2", 64'(lane(2)), 64'hE1);
    chk("nc_valid", 64'(q_if.deqValid_o), 64'h7);

    // Reset mid-operation beats enqueue and pop.
    set_enq(4, 32'hF0);
    q_if.deqPop_i = 3'd2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_enq(0, 0);
    q_if.deqPop_i = 3'd0;
    #1;
    chk("mrst_count", 64'(q_if.count_o), 64'd0);
    chk("mrst_empty", 64'(q_if.empty_o), 64'd1);
    chk("mrst_ready", 64'(q_if.enqReady_o), 64'd1);
    chk("mrst_head", 64'(q_if.head_o), 64'd0);
    chk("mrst_tail", 64'(q_if.tail_o), 64'd0);
`ifdef IIQ_STATS_EN
    chk("mrst_hw", 64'(high_water), 64'd0);
    chk("mrst_stall", 64'(stall_cycles), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/multi_issue_inst_queue.md
MULTI_ISSUE_INST_QUEUE -- requirements
Module: multi_issue_inst_queue

Interface
REQ-001 SHALL have parameter ENQ_LANES, default 4: decoder-side enqueue lanes per cycle.
REQ-002 SHALL have parameter DEQ_LANES, default 4: backend-side dequeue lanes per cycle.
REQ-003 SHALL have parameter ENTRY_W, default 256: packed per-instruction payload bits, opaque to the queue.
REQ-004 SHALL have parameter DEPTH_LOG2, default 4: entries = 2**DEPTH_LOG2, which SHALL be >= max(ENQ_LANES, DEQ_LANES).
REQ-005 SHALL have port clock_i  in  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_i  in  1: synchronous, active-low reset.
REQ-007 SHALL have port flush_i  in  1: discard all queued entries.
REQ-008 SHALL have port enqValid_i  in  ENQ_LANES: per-lane valid, contiguous from lane 0.
REQ-009 SHALL have port enqData_i  in  ENQ_LANES*ENTRY_W: lane 0 in the most-significant slice.
REQ-010 SHALL have port enqReady_o  out  1: the whole enqueue group is accepted this cycle.
REQ-011 SHALL have port deqValid_o  out  DEQ_LANES: lane i holds entry head+i.
REQ-012 SHALL have port deqData_o  out  DEQ_LANES*ENTRY_W: head window.
REQ-013 SHALL have port deqPop_i  in  clog2(DEQ_LANES+1): number of entries consumed this cycle.
REQ-014 SHALL have port count_o  out  DEPTH_LOG2+1: occupancy.
REQ-015 SHALL have port head_o, tail_o  out  DEPTH_LOG2 each.
REQ-016 SHALL have port empty_o, full_o  out  1 each.

Function
REQ-017 SHALL drive enqReady_o = (entries - count) >= popcount(enqValid_i); acceptance is all-or-none, and no partial group is written.
REQ-018 SHALL write accepted lane k to slot (tail+k) mod entries, then advance tail by popcount.
REQ-019 SHALL operate first-word-fall-through: deqValid_o[i] = (count > i), deqData_o lane i = slot (head+i) mod entries, combinational from registered state, with zero-cycle read latency.
REQ-020 SHALL advance head by deqPop_i mod entries; a deqPop_i greater than the number of valid lanes is illegal, and the queue SHALL clamp it to that number.
REQ-021 SHALL apply enqueue and dequeue in the same cycle: count_next = count + enq - pop; enqReady_o SHALL use the pre-cycle count, with no bypass of same-cycle pops.
REQ-022 SHALL treat flush_i as priority over enqueue and pop: next cycle head = tail = count = 0, and that cycle's enqueue is dropped.
REQ-023 SHALL drive empty_o = (count == 0) and full_o = (count == entries); head and tail wrap modulo entries.
REQ-024 SHALL treat non-contiguous enqValid_i as illegal; the queue SHALL use only the leading run of ones.

Reset
REQ-025 SHALL, with reset_i low at a clock edge, set head = tail = count = 0, giving outputs deqValid_o = 0, empty_o = 1, full_o = 0, enqReady_o = 1.
REQ-026 SHALL give reset priority over flush, enqueue and pop; reset mid-operation discards all contents, and payload RAM is not cleared.

Configuration
REQ-027 SHALL, with IIQ_STATS_EN defined, add outputs highWater_o (DEPTH_LOG2+1, maximum count since reset) and stallCycles_o (32, cycles with any enqValid_i and enqReady_o low, saturating); both are cleared by reset and not by flush.
REQ-028 SHALL, without IIQ_STATS_EN, have neither port nor counter logic.

Structure
REQ-029 SHALL place default parameter constants and the lane-slice width helper in shared package inst_queue_pkg.
REQ-030 SHALL isolate storage in sub-module iiq_ram: ENQ_LANES write ports, DEQ_LANES asynchronous read ports, entries x ENTRY_W.

Verification (DEPTH_LOG2=4, lanes 4)
REQ-031 SHALL cover: reset, then enqueue 4 with payloads 0..3 -> next cycle count_o = 4, deqValid_o = 1111, lane 0 = 0.
REQ-032 SHALL cover: 12 held, 4 valid with pop 0 -> accepted, full_o = 1; next group -> enqReady_o = 0 and count remains 16.
REQ-033 SHALL cover: tail = 14, enqueue 4 -> slots 14, 15, 0, 1 written; tail_o = 2; data read back in order.
REQ-034 SHALL cover: count = 3, enqueue 2 and deqPop_i = 3 in one cycle -> count_o = 2, head advances 3.
REQ-035 SHALL cover: flush_i with enqueue 4 in one cycle -> count_o = 0, empty_o = 1, and the enqueued data is absent.
REQ-036 SHALL cover: IIQ_STATS_EN defined, 5 blocked cycles -> stallCycles_o = 5; highWater_o = 16 persists after flush.
